// File: rtl/sbc_unit.sv
// sbc_unit: nibble-serial 6502 SBC (A + ~B + C) with C/V/N/Z flags.
// One operation walks IDLE/DONE -> LO -> HI -> ADJ -> DONE, three cycles
// from the accepted start edge to the done pulse.
// Optional NMOS-style BCD adjust is compiled in with `define SBC_DECIMAL_EN;
// without it the D input is captured but has no effect and S is the binary
// result. The flags always come from the binary result in either build.
module sbc_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  input  logic       D,
  output logic [7:0] S,
  output logic       C,
  output logic       V,
  output logic       N,
  output logic       Z,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_ADJ,
    ST_DONE
  } state_t;

  state_t     r_state;

  // Operands captured at start acceptance
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic       r_cin;
  logic       r_d;

  // Partial results from the two nibble steps
  logic [3:0] r_lo;
  logic       r_c4;
  logic [3:0] r_hi;
  logic       r_c8;

  // Registered outputs
  logic [7:0] r_s;
  logic       r_c;
  logic       r_v;
  logic       r_n;
  logic       r_z;
  logic       r_busy;
  logic       r_done;

  logic [4:0] w_lo_sum;
  logic [4:0] w_hi_sum;
  logic [7:0] w_r;
  logic [7:0] w_s_dec;
  logic [7:0] w_s_final;
  logic       w_dec_en;
  logic       w_v;

  // Nibble adders: the inverted subtrahend plus incoming carry gives subtraction
  assign w_lo_sum = {1'b0, r_a[3:0]} + {1'b0, ~r_b[3:0]} + {4'd0, r_cin};
  assign w_hi_sum = {1'b0, r_a[7:4]} + {1'b0, ~r_b[7:4]} + {4'd0, r_c4};

  assign w_r = {r_hi, r_lo};

  // Signed overflow: operand signs differ and result sign differs from A
  assign w_v = (r_a[7] ^ r_b[7]) & (r_a[7] ^ w_r[7]);

  // Per-nibble decimal correction; a nibble that borrowed drops by 6, no
  // borrow propagates between the nibbles
  assign w_s_dec[3:0] = r_c4 ? r_lo : (r_lo - 4'h6);
  assign w_s_dec[7:4] = r_c8 ? r_hi : (r_hi - 4'h6);

`ifdef SBC_DECIMAL_EN
  assign w_dec_en = r_d;
`else
  // Decimal support is compiled out; the captured D flag is masked off
  assign w_dec_en = r_d & 1'b0;
`endif

  assign w_s_final = w_dec_en ? w_s_dec : w_r;

  // Sequencer: captures operands, steps the nibble adders, publishes results
  // NOTE: every register here uses <= so all updates see pre-edge values;
  // a blocking assignment would let later lines read same-cycle results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= 8'h00;
      r_b     <= 8'h00;
      r_cin   <= 1'b0;
      r_d     <= 1'b0;
      r_lo    <= 4'h0;
      r_c4    <= 1'b0;
      r_hi    <= 4'h0;
      r_c8    <= 1'b0;
      r_s     <= 8'h00;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
      r_n     <= 1'b0;
      r_z     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_cin   <= Cin;
            r_d     <= D;
            r_busy  <= 1'b1;
            r_state <= ST_LO;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_LO: begin
          {r_c4, r_lo} <= w_lo_sum;
          r_state      <= ST_HI;
        end
        ST_HI: begin
          {r_c8, r_hi} <= w_hi_sum;
          r_state      <= ST_ADJ;
        end
        ST_ADJ: begin
          r_s     <= w_s_final;
          r_c     <= r_c8;
          r_v     <= w_v;
          r_n     <= w_r[7];
          r_z     <= (w_r == 8'h00);
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign S    = r_s;
  assign C    = r_c;
  assign V    = r_v;
  assign N    = r_n;
  assign Z    = r_z;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: doc/sbc_unit.md
# sbc_unit

Multi-cycle subtract-with-borrow unit implementing the 6502 SBC operation as A + ~B + C, nibble-serial. It is the subtract-direction companion to the datapath's 8-bit carry-lookahead adder. It sits beside the ALU and is launched by the control sequencer with a start/done handshake. It produces the result and the C, V, N, Z flags, with an optional NMOS-style decimal (BCD) adjust.

## Interface
Parameters:
- none (width fixed at 8 bits; decimal support is selected by macro, see Configuration)

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  launch request; sampled on the rising edge, accepted only in IDLE or DONE
- `A`  in  8  minuend; captured when start is accepted
- `B`  in  8  subtrahend; captured when start is accepted
- `Cin`  in  1  carry in (1 = no borrow); captured when start is accepted
- `D`  in  1  decimal-mode flag; captured when start is accepted
- `S`  out  8  result
- `C`  out  1  carry out (1 = no borrow)
- `V`  out  1  signed overflow
- `N`  out  1  negative flag
- `Z`  out  1  zero flag
- `busy`  out  1  high in LO, HI and ADJ
- `done`  out  1  high for exactly one cycle, in DONE

## Operation
- States: IDLE, LO, HI, ADJ, DONE. Encoding is free; the state is registered.
- IDLE or DONE with `start`=1: latch A, B, Cin, D, then go to LO. In IDLE with `start`=0, stay in IDLE. In DONE with `start`=0, go to IDLE.
- LO: compute {c4, lo} = A[3:0] + ~B[3:0] + Cin (5-bit), then go to HI.
- HI: compute {c8, hi} = A[7:4] + ~B[7:4] + c4 (5-bit), then go to ADJ. The binary result is R = {hi, lo}.
- ADJ: form the flags and the final S, then go to DONE.
  - C = c8.
  - V = (A[7]^B[7]) & (A[7]^R[7]).
  - N = R[7].
  - Z = (R == 8'h00).
  - N, Z, V and C are always taken from the binary result, including in decimal mode (NMOS behaviour).
  - Decimal adjust applies only when D=1 and the macro is enabled: if c4=0, subtract 4'h6 from the low nibble (mod 16); if c8=0, subtract 4'h6 from the high nibble (mod 16). No cross-nibble borrow. Otherwise S = R.
- S, C, V, N, Z are registered. They update only on the edge leaving ADJ and hold their values until the next operation's ADJ completes.
- `start` in LO, HI or ADJ is ignored; no queuing.
- Invalid BCD operands in decimal mode: no error; the result follows the rules above.

## Timing
- Reset (`rst_n`=0, asynchronous): state becomes IDLE; S=8'h00; C=V=N=Z=0; busy=0; done=0. Latched operands are cleared.
- Reset asserted mid-operation aborts immediately. No done pulse follows.
- Start accepted on edge E0 gives: LO during E0→E1, HI during E1→E2, ADJ during E2→E3, DONE during E3→E4 (done=1, outputs valid).
- Latency from start edge to done: 3 cycles. Latency is identical in binary and decimal mode.
- Back-to-back: `start` held high during DONE is accepted at E4. Throughput is one operation per 4 cycles. done stays a single-cycle pulse per operation.
- busy and done are never high together, and are both low in IDLE.

## Configuration
- `SBC_DECIMAL_EN` defined: the D input is honoured and the ADJ state applies the BCD adjust.
- `SBC_DECIMAL_EN` undefined: D is ignored and S = R always. ADJ is still traversed, so latency is unchanged at 3 cycles. Flags are unaffected by the macro.

## Test plan
- Reset: drive `rst_n` low with random inputs. Required: S=00, C=V=N=Z=0, busy=0, done=0, independent of clk.
- Binary: A=50, B=B0, Cin=1, D=0, pulse start. Required: done exactly 3 cycles later with S=A0, C=0, V=1, N=1, Z=0.
- Zero/carry: A=05, B=05, Cin=1, D=0. Required: S=00, C=1, Z=1, V=0, N=0.
- Decimal (macro on):
  - A=42, B=17, Cin=1, D=1. Required: S=25, C=1, N=0, Z=0.
  - A=00, B=01, Cin=1, D=1. Required: S=99, C=0, N=1, Z=0.
  - Macro off, A=42, B=17, Cin=1, D=1. Required: S=2B.
- Handshake: hold start high for 12 cycles. Required: exactly 3 done pulses, 4 cycles apart; start during busy is ignored.
- Abort: assert `rst_n`=0 in HI of an operation. Required: outputs cleared immediately; no done pulse; the next start runs normally.
